fpu_ret_collect: RTL and testbench
==================================

# fpu_ret_collect

Retire-side collector directly downstream of the three-unit half-width FPU cluster. Each cycle it accepts up to three FPU completion words (`u1_ret`, `u3_ret`, `u5_ret` with their enables) and packs them in lane order into a 16-entry in-order queue. It hands entries one per cycle to the retire logic over a valid/ready handshake. As entries retire, it accumulates IEEE exception flags into a sticky register and raises a trap request for any flag that `fpcsr` enables.

## Interface
Parameters:
- `DEPTH`, default 16: queue entries; must be a power of two, at least 8.
- `STALL_TH`, default 10: registered-stall threshold on next occupancy.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `u1_ret`, `u3_ret`, `u5_ret`, in, 14 each: completion words. Bits [4:0] are flags {inexact, underflow, overflow, divzero, invalid}. Bits [13:5] are the retire tag.
- `u1_ret_en`, `u3_ret_en`, `u5_ret_en`, in, 1 each: completion valid.
- `fpcsr`, in, 32: bits [12:8] are per-flag trap enables (1 = trap).
- `ret_data`, out, 16: {lane[1:0], ret[13:0]}, with lane 0/1/2 = u1/u3/u5.
- `ret_vld`, out, 1: queue head valid.
- `ret_rdy`, in, 1: retire consumer accepts the head.
- `fpu_stall`, out, 1: registered backpressure to the FPU issue stage.
- `csr_wr_en`, in, 1: software write of the sticky flags.
- `csr_wr_data`, in, 5: new sticky value.
- `sticky_flags`, out, 5: accumulated flags.
- `q_ovf`, out, 1: sticky overflow error; cleared only by `rst`.
- `trap_req`, out, 1: one-cycle trap pulse.
- `trap_code`, out, 16: `ret_data` of the trapping entry.

## Operation
- Packing: enabled lanes are compacted in fixed order u1, u3, u5 into consecutive slots starting at the write pointer. Disabled lanes leave no gap.
- Pointers: `wp` and `rp` are log2(DEPTH)+1 bits wide. The MSB is the wrap bit. Full when indices are equal and wrap bits differ; empty when both are equal.
- Count: `count` is 0..DEPTH. `count_next = count + pushes - pop`, where `pushes` is 0..3 and `pop` is `ret_vld & ret_rdy`.
- Overflow: if `pushes` exceeds free slots (counting the same-cycle pop as freeing one):
  - Accepted lanes are the first `free` in packing order.
  - The remaining lanes are dropped.
  - `q_ovf` is set.
  - This is a protocol violation guarded by `fpu_stall`.
- Head is first-word-fall-through: `ret_vld = !empty`, and `ret_data` is the head slot. Pushes and a pop in the same cycle are legal at any occupancy, including empty, where a pushed word becomes visible only the next cycle.
- Sticky update on pop:
  - `sticky_next = (csr_wr_en ? csr_wr_data : sticky) | (pop ? head_flags : 0)`.
  - A CSR write in the same cycle as a pop keeps the popped flags.
- Trap: on a pop with `head_flags & fpcsr[12:8]` nonzero, `trap_req` pulses the next cycle and `trap_code` latches the popped `ret_data`. `trap_code` holds until the next trap.
- Reset mid-operation: queue is emptied, in-flight pushes are discarded, and all state is cleared.

## Timing
- Reset values: `ret_vld` 0, `ret_data` 0, `fpu_stall` 0, `sticky_flags` 0, `q_ovf` 0, `trap_req` 0, `trap_code` 0. The queue RAM is not cleared; `ret_data` is gated to 0 while empty.
- Push to `ret_vld`: 1 cycle.
- Pop to `sticky_flags` update: 1 cycle.
- Pop to `trap_req`: 1 cycle.
- `fpu_stall <= (count_next > STALL_TH)`. This reserves two cycles of three-wide pushes of slack for the FPU issue latency.
- The handshake allows `ret_rdy` to be held high permanently. `ret_data` must be stable while `ret_vld & !ret_rdy`.

## Configuration
- `FPU_RETQ_TRAP_EN` defined: trap logic as above.
- Undefined: `trap_req` and `trap_code` are tied to 0, and `fpcsr` is unused. Flags still accumulate into `sticky_flags`.

## Structure
- Shared package `fpu_retq_pkg` holds:
  - Flag bit index constants: `FLG_INV`=0, `FLG_DZ`=1, `FLG_OVF`=2, `FLG_UNF`=3, `FLG_INX`=4.
  - `FPCSR_TEN_LSB`=8.
  - Lane code constants.
  - The `ret_entry_t` typedef {lane, tag, flags}.
- One sub-module, `fpu_retq_pack`: a combinational 3-to-3 compactor producing packed words, push count and per-slot write enables. The top level holds pointers, RAM, sticky and trap registers.

## Test plan
- Push one entry per lane with `ret_rdy`=0 and `u1_ret`=14'h0021, `u3` off, `u5_ret`=14'h0040:
  - Cycle+1: `ret_vld`=1, `ret_data`=16'h0021.
  - After raising `ret_rdy`: next `ret_data`=16'h8040.
  - Then `ret_vld` drops.
- All three lanes every cycle with `ret_rdy`=0:
  - `fpu_stall` rises the cycle after `count_next` reaches 12.
  - Ignoring stall until 16 is exceeded sets `q_ovf`=1 and keeps exactly 16 entries in order.
- Wrap-around: stream 40 entries with `ret_rdy` random at 50% while obeying `fpu_stall`. The output sequence must equal the input in lane-packed order with no loss.
- Pop an entry with flags 5'b00100 and `fpcsr[12:8]`=5'b00100:
  - Cycle+1: `sticky_flags`=5'b00100, `trap_req`=1 for one cycle, `trap_code` = that entry.
  - With enables 0: no trap.
- Same cycle: `csr_wr_en`=1 with `csr_wr_data`=0, plus a pop with flags 5'b10000. Required: `sticky_flags`=5'b10000.
- Assert `rst` with 5 queued entries and a push in flight. Next cycle: `ret_vld`=0 and all outputs zero. The first post-reset push appears alone.

Source files
------------

// File: rtl/fpu_retq_pkg.sv
// Shared constants and the queue-entry layout of the FPU retire collector.
package fpu_retq_pkg;

  localparam int unsigned FLG_INV = 0;
  localparam int unsigned FLG_DZ  = 1;
  localparam int unsigned FLG_OVF = 2;
  localparam int unsigned FLG_UNF = 3;
  localparam int unsigned FLG_INX = 4;

  localparam int unsigned FPCSR_TEN_LSB = 8;

  localparam logic [1:0] LANE_U1 = 2'd0;
  localparam logic [1:0] LANE_U3 = 2'd1;
  localparam logic [1:0] LANE_U5 = 2'd2;

  typedef struct packed {
    logic [1:0] lane;
    logic [8:0] tag;
    logic [4:0] flags;
  } ret_entry_t;

endpackage

// File: rtl/fpu_ret_collect_if.sv
// Retire-side valid/ready handshake between the collector and the retire logic.
interface fpu_ret_collect_if;
  logic [15:0] ret_data;
  logic        ret_vld;
  logic        ret_rdy;

  modport master (output ret_data, output ret_vld, input ret_rdy);
  modport slave  (input ret_data, input ret_vld, output ret_rdy);
endinterface

// File: rtl/fpu_retq_pack.sv
// Combinational compactor: enabled lanes u1, u3, u5 packed gap-free into slots 0..2.
module fpu_retq_pack
  import fpu_retq_pkg::*;
(
  input  logic [13:0]      u1_ret,
  input  logic [13:0]      u3_ret,
  input  logic [13:0]      u5_ret,
  input  logic             u1_ret_en,
  input  logic             u3_ret_en,
  input  logic             u5_ret_en,
  output ret_entry_t [2:0] slot,
  output logic [1:0]       push_cnt,
  output logic [2:0]       slot_we
);

  ret_entry_t e1, e3, e5;

  assign e1 = {LANE_U1, u1_ret};
  assign e3 = {LANE_U3, u3_ret};
  assign e5 = {LANE_U5, u5_ret};

  assign push_cnt = {1'b0, u1_ret_en} + {1'b0, u3_ret_en} + {1'b0, u5_ret_en};

  always_comb begin
    slot[0] = u1_ret_en ? e1 : (u3_ret_en ? e3 : e5);
    slot[1] = (u1_ret_en && u3_ret_en) ? e3 : e5;
    slot[2] = e5;
    slot_we = '0;
    for (int unsigned k = 0; k < 3; k++)
      slot_we[k] = (2'(k) < push_cnt);
  end

endmodule

// File: rtl/fpu_ret_collect.sv
// FPU retire collector: packed in-order queue, sticky IEEE flags, optional trap
// request (trap logic enabled by defining FPU_RETQ_TRAP_EN).
module fpu_ret_collect
  import fpu_retq_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned STALL_TH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [13:0]               u1_ret,
  input  logic [13:0]               u3_ret,
  input  logic [13:0]               u5_ret,
  input  logic                      u1_ret_en,
  input  logic                      u3_ret_en,
  input  logic                      u5_ret_en,
  input  logic [31:0]               fpcsr,
  fpu_ret_collect_if.master         retq,
  output logic                      fpu_stall,
  input  logic                      csr_wr_en,
  input  logic [4:0]                csr_wr_data,
  output logic [4:0]                sticky_flags,
  output logic                      q_ovf,
  output logic                      trap_req,
  output logic [15:0]               trap_code
);

  localparam int unsigned AW = $clog2(DEPTH);

  ret_entry_t [2:0] slot;
  logic [1:0]       push_cnt;
  logic [2:0]       slot_we;

  fpu_retq_pack u_pack (
    .u1_ret    (u1_ret),
    .u3_ret    (u3_ret),
    .u5_ret    (u5_ret),
    .u1_ret_en (u1_ret_en),
    .u3_ret_en (u3_ret_en),
    .u5_ret_en (u5_ret_en),
    .slot      (slot),
    .push_cnt  (push_cnt),
    .slot_we   (slot_we)
  );

  ret_entry_t mem [DEPTH];
  logic [AW:0] wp, rp, count, free, count_next;
  logic [1:0]  n_acc;
  logic        empty, pop, ovf_hit;
  ret_entry_t  head;

  assign count   = wp - rp;
  assign empty   = (wp == rp);
  assign pop     = ~empty & retq.ret_rdy;
  assign head    = mem[rp[AW-1:0]];

  // A same-cycle pop frees one slot; excess lanes beyond free are dropped in packing order.
  assign free    = (AW+1)'(DEPTH) - count + {{AW{1'b0}}, pop};
  assign ovf_hit = ({{(AW-1){1'b0}}, push_cnt} > free);
  assign n_acc   = ovf_hit ? free[1:0] : push_cnt;
  assign count_next = count + {{(AW-1){1'b0}}, n_acc} - {{AW{1'b0}}, pop};

  assign retq.ret_vld  = ~empty;
  assign retq.ret_data = empty ? '0 : head;

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < 3; k++)
      if (slot_we[k] && (2'(k) < n_acc))
        mem[wp[AW-1:0] + AW'(k)] <= slot[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp           <= '0;
      rp           <= '0;
      fpu_stall    <= 1'b0;
      sticky_flags <= '0;
      q_ovf        <= 1'b0;
    end else begin
      wp           <= wp + {{(AW-1){1'b0}}, n_acc};
      rp           <= rp + {{AW{1'b0}}, pop};
      fpu_stall    <= (count_next > (AW+1)'(STALL_TH));
      q_ovf        <= q_ovf | ovf_hit;
      sticky_flags <= (csr_wr_en ? csr_wr_data : sticky_flags) | (pop ? head.flags : 5'b0);
    end
  end

`ifdef FPU_RETQ_TRAP_EN
  logic [4:0] trap_en;
  logic [26:0] unused_fpcsr;

  assign trap_en      = fpcsr[FPCSR_TEN_LSB +: 5];
  assign unused_fpcsr = {fpcsr[31:FPCSR_TEN_LSB+5], fpcsr[FPCSR_TEN_LSB-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      trap_req  <= 1'b0;
      trap_code <= '0;
    end else begin
      trap_req <= pop && |(head.flags & trap_en);
      if (pop && |(head.flags & trap_en))
        trap_code <= head;
    end
  end
`else
  logic unused_fpcsr;

  assign unused_fpcsr = ^fpcsr;
  assign trap_req     = 1'b0;
  assign trap_code    = '0;
`endif

endmodule

// File: tb/tb_fpu_ret_collect.sv
// Self-checking bench for fpu_ret_collect: vector table, directed corner cases and
// a randomized stream against a queue-based reference model.
module tb_fpu_ret_collect;

  localparam int DEPTH    = 16;
  localparam int STALL_TH = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] u1_ret, u3_ret, u5_ret;
  logic        u1_ret_en, u3_ret_en, u5_ret_en;
  logic [31:0] fpcsr;
  logic        fpu_stall;
  logic        csr_wr_en;
  logic [4:0]  csr_wr_data;
  logic [4:0]  sticky_flags;
  logic        q_ovf;
  logic        trap_req;
  logic [15:0] trap_code;

  fpu_ret_collect_if retq ();

  fpu_ret_collect #(.DEPTH(DEPTH), .STALL_TH(STALL_TH)) dut (
    .clk          (clk),
    .rst          (rst),
    .u1_ret       (u1_ret),
    .u3_ret       (u3_ret),
    .u5_ret       (u5_ret),
    .u1_ret_en    (u1_ret_en),
    .u3_ret_en    (u3_ret_en),
    .u5_ret_en    (u5_ret_en),
    .fpcsr        (fpcsr),
    .retq         (retq.master),
    .fpu_stall    (fpu_stall),
    .csr_wr_en    (csr_wr_en),
    .csr_wr_data  (csr_wr_data),
    .sticky_flags (sticky_flags),
    .q_ovf        (q_ovf),
    .trap_req     (trap_req),
    .trap_code    (trap_code)
  );

  always #5 clk = ~clk;

`ifdef FPU_RETQ_TRAP_EN
  localparam bit TRAP_BUILD = 1'b1;
`else
  localparam bit TRAP_BUILD = 1'b0;
`endif

  int nvec = 0;
  int nerr = 0;
  int n_popped = 0;

  logic [15:0] mq[$];
  logic        m_stall, m_ovf, m_trap;
  logic [4:0]  m_sticky;
  logic [15:0] m_code;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] en, input logic [13:0] w1, input logic [13:0] w3,
                       input logic [13:0] w5, input logic rdy);
    u1_ret_en = en[0]; u3_ret_en = en[1]; u5_ret_en = en[2];
    u1_ret = w1; u3_ret = w3; u5_ret = w5;
    retq.ret_rdy = rdy;
  endtask

  // Reference: advance the queue model from the currently driven inputs, clock, compare.
  task automatic cycle();
    logic [15:0] w[$];
    logic [15:0] hd;
    bit pop;
    int free;
    if (rst) begin
      mq.delete();
      m_stall = 0; m_ovf = 0; m_trap = 0; m_sticky = '0; m_code = '0;
    end else begin
      pop = (mq.size() > 0) && retq.ret_rdy;
      hd  = pop ? mq[0] : 16'h0;
      if (u1_ret_en) w.push_back({2'd0, u1_ret});
      if (u3_ret_en) w.push_back({2'd1, u3_ret});
      if (u5_ret_en) w.push_back({2'd2, u5_ret});
      free = DEPTH - mq.size() + int'(pop);
      if (w.size() > free) m_ovf = 1;
      m_sticky = (csr_wr_en ? csr_wr_data : m_sticky) | hd[4:0];
      m_trap = TRAP_BUILD && pop && ((hd[4:0] & fpcsr[12:8]) != 0);
      if (m_trap) m_code = hd;
      if (pop) begin void'(mq.pop_front()); n_popped++; end
      for (int i = 0; i < w.size() && i < free; i++) mq.push_back(w[i]);
      m_stall = mq.size() > STALL_TH;
    end
    @(posedge clk); #1;
    chk("ret_vld", {15'd0, retq.ret_vld}, {15'd0, mq.size() > 0});
    chk("ret_data", retq.ret_data, (mq.size() > 0) ? mq[0] : 16'h0);
    chk("fpu_stall", {15'd0, fpu_stall}, {15'd0, m_stall});
    chk("sticky", {11'd0, sticky_flags}, {11'd0, m_sticky});
    chk("q_ovf", {15'd0, q_ovf}, {15'd0, m_ovf});
    chk("trap_req", {15'd0, trap_req}, {15'd0, m_trap});
    chk("trap_code", trap_code, m_code);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(3'b000, '0, '0, '0, 1'b0);
    cycle();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  en;
    logic [13:0] w1, w3, w5;
    logic        rdy;
    logic        evld;
    logic [15:0] edata;
  } vec_t;

  vec_t tbl[8];
  int   tag;
  int   issued;
  int   budget;
  logic [2:0] en;

  initial begin
    tbl[0] = '{3'b101, 14'h0021, 14'h0000, 14'h0040, 1'b0, 1'b1, 16'h0021};
    tbl[1] = '{3'b000, 14'h0000, 14'h0000, 14'h0000, 1'b1, 1'b1, 16'h8040};
    tbl[2] = '{3'b000, 14'h0000, 14'h0000, 14'h0000, 1'b1, 1'b0, 16'h0000};
    tbl[3] = '{3'b010, 14'h0000, 14'h1ABC, 14'h0000, 1'b0, 1'b1, 16'h5ABC};
    tbl[4] = '{3'b111, 14'h0001, 14'h0002, 14'h0003, 1'b1, 1'b1, 16'h0001};
    tbl[5] = '{3'b000, 14'h0000, 14'h0000, 14'h0000, 1'b1, 1'b1, 16'h4002};
    tbl[6] = '{3'b000, 14'h0000, 14'h0000, 14'h0000, 1'b1, 1'b1, 16'h8003};
    tbl[7] = '{3'b000, 14'h0000, 14'h0000, 14'h0000, 1'b1, 1'b0, 16'h0000};

    fpcsr = '0; csr_wr_en = 1'b0; csr_wr_data = '0;
    do_reset();
    do_reset();
    chk("rst_vld", {15'd0, retq.ret_vld}, 16'd0);
    chk("rst_data", retq.ret_data, 16'd0);

    // Vector table: packing, lane codes, fall-through head.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].en, tbl[i].w1, tbl[i].w3, tbl[i].w5, tbl[i].rdy);
      cycle();
      chk($sformatf("tbl%0d_vld", i), {15'd0, retq.ret_vld}, {15'd0, tbl[i].evld});
      chk($sformatf("tbl%0d_data", i), retq.ret_data, tbl[i].edata);
    end
    chk("tbl_sticky", {11'd0, sticky_flags}, 16'h001F);

    // Fill three-wide with no retire: stall after count 12, overflow past 16.
    do_reset();
    tag = 1;
    for (int k = 1; k <= 8; k++) begin
      drive(3'b111, 14'(tag << 5), 14'((tag + 1) << 5), 14'((tag + 2) << 5), 1'b0);
      tag += 3;
      cycle();
      if (k == 3) chk("stall_at9", {15'd0, fpu_stall}, 16'd0);
      if (k == 4) chk("stall_at12", {15'd0, fpu_stall}, 16'd1);
      if (k == 5) chk("ovf_at15", {15'd0, q_ovf}, 16'd0);
    end
    chk("ovf_set", {15'd0, q_ovf}, 16'd1);
    n_popped = 0;
    for (int k = 0; k < 16; k++) begin
      drive(3'b000, '0, '0, '0, 1'b1);
      cycle();
    end
    chk("ovf_kept16", 16'(n_popped), 16'd16);
    chk("ovf_empty", {15'd0, retq.ret_vld}, 16'd0);

    // Randomized wrap-around stream obeying fpu_stall.
    do_reset();
    issued = 0; n_popped = 0; budget = 0;
    while ((issued < 40 || mq.size() > 0) && budget < 1000) begin
      en = 3'($urandom);
      if (fpu_stall || issued >= 40) en = 3'b000;
      for (int b = 0; b < 3; b++)
        if (en[b]) begin
          if (issued < 40) issued++;
          else en[b] = 1'b0;
        end
      drive(en, 14'($urandom), 14'($urandom), 14'($urandom), 1'($urandom));
      cycle();
      budget++;
    end
    chk("stream_budget", {15'd0, budget < 1000}, 16'd1);
    chk("stream_count", 16'(n_popped), 16'd40);
    chk("stream_no_ovf", {15'd0, q_ovf}, 16'd0);

    // Trap on enabled flag, then disabled enables give no trap.
    do_reset();
    fpcsr = 32'h0000_0400;
    drive(3'b001, 14'h0124, '0, '0, 1'b0);
    cycle();
    drive(3'b000, '0, '0, '0, 1'b1);
    cycle();
    chk("trap_sticky", {11'd0, sticky_flags}, 16'h0004);
    chk("trap_pulse", {15'd0, trap_req}, {15'd0, TRAP_BUILD});
    chk("trap_code_v", trap_code, TRAP_BUILD ? 16'h0124 : 16'h0000);
    drive(3'b000, '0, '0, '0, 1'b0);
    cycle();
    chk("trap_one_cycle", {15'd0, trap_req}, 16'd0);
    fpcsr = '0;
    drive(3'b010, '0, 14'h0204, '0, 1'b0);
    cycle();
    drive(3'b000, '0, '0, '0, 1'b1);
    cycle();
    chk("notrap", {15'd0, trap_req}, 16'd0);
    chk("notrap_hold", trap_code, TRAP_BUILD ? 16'h0124 : 16'h0000);

    // CSR write coinciding with a pop keeps the popped flags.
    drive(3'b100, '0, '0, 14'h0310, 1'b0);
    cycle();
    csr_wr_en = 1'b1; csr_wr_data = 5'b0;
    drive(3'b000, '0, '0, '0, 1'b1);
    cycle();
    csr_wr_en = 1'b0;
    chk("csr_pop_sticky", {11'd0, sticky_flags}, 16'h0010);

    // Reset with 5 queued entries and a push in flight.
    drive(3'b111, 14'h0011, 14'h0012, 14'h0013, 1'b0);
    cycle();
    drive(3'b011, 14'h0014, 14'h0015, '0, 1'b0);
    cycle();
    rst = 1'b1;
    drive(3'b111, 14'h0016, 14'h0017, 14'h0018, 1'b0);
    cycle();
    rst = 1'b0;
    chk("rst_mid_vld", {15'd0, retq.ret_vld}, 16'd0);
    chk("rst_mid_data", retq.ret_data, 16'd0);
    chk("rst_mid_misc", {fpu_stall, q_ovf, trap_req, sticky_flags, 8'd0}, 16'd0);
    drive(3'b010, '0, 14'h0A00, '0, 1'b0);
    cycle();
    chk("post_rst_data", retq.ret_data, 16'h4A00);
    drive(3'b000, '0, '0, '0, 1'b1);
    cycle();
    chk("post_rst_alone", {15'd0, retq.ret_vld}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
